calc_operand_mem: RTL and testbench

Parametrised operand and result memory for the calculator datapath. Collects keypad digits into two operands, latches the pending operator, and captures ALU results on equals. Keeps a ring-buffer history of past results that can be recalled into the active operand. Sits between the keypad decoder and the ALU/display, and replaces the fixed two-register store.

---
 rtl/calc_operand_mem.sv | 200 ++++++++++++++++++++
 tb/tb_calc_operand_mem.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_operand_mem.sv
// calc_operand_mem
// Operand and result store for the calculator datapath. Keypad digits are
// shifted into operand A (save1) or operand B (save2), the pending operator is
// latched one-hot, and ALU results are captured on equals. Every captured
// result is also pushed into a small ring-buffer history. A history entry can
// be recalled into the active operand.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   num             4-bit digit code from the keypad decoder
//   digit_enable    append num to the active operand
//   back_enable     delete the last entered digit
//   operator        2-bit operator code
//   op_enable       latch operator
//   equ_enable      capture res into save1 and the history
//   res             ALU result (combinational from save1/save2/op_out)
//   recall_enable   load history entry recall_idx (0 = newest)
//   recall_idx      history entry to load
//   clear_enable    clear operands and operator, history is kept
//   save1, save2    operand A / operand B
//   op_out          one-hot latched operator, 0 = none
//   active_b        operand B is receiving digits
//   digit_cnt       digits held in the active operand
//   entry_full      digit_cnt == DIGITS
//   hist_count      valid history entries (saturates at HIST_DEPTH)
//   err             one-cycle pulse for a rejected command
//
// Command priority (one per cycle): clear > equ > op > recall > back > digit.

module calc_operand_mem #(
  parameter int DIGITS     = 4,
  parameter int HIST_DEPTH = 4,
  parameter bit DECIMAL    = 1'b1,
  localparam int W  = 4 * DIGITS,
  localparam int HW = $clog2(HIST_DEPTH),
  localparam int CW = $clog2(DIGITS) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    num,
  input  logic          digit_enable,
  input  logic          back_enable,
  input  logic [1:0]    operator,
  input  logic          op_enable,
  input  logic          equ_enable,
  input  logic [W-1:0]  res,
  input  logic          recall_enable,
  input  logic [HW-1:0] recall_idx,
  input  logic          clear_enable,
  output logic [W-1:0]  save1,
  output logic [W-1:0]  save2,
  output logic [3:0]    op_out,
  output logic          active_b,
  output logic [CW-1:0] digit_cnt,
  output logic          entry_full,
  output logic [HW:0]   hist_count,
  output logic          err
);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    RESULT  = 2'd2
  } state_t;

  localparam logic [CW-1:0] DIGITS_C  = DIGITS[CW-1:0];
  localparam logic [HW:0]   HIST_FULL = HIST_DEPTH[HW:0];

  state_t        state, state_d;
  logic [W-1:0]  save1_d, save2_d;
  logic [3:0]    op_d;
  logic [CW-1:0] cnt_d;
  logic          err_d;
  logic          push;

  logic [W-1:0]  hist [HIST_DEPTH];
  logic [HW-1:0] wptr;

  logic [W-1:0]  active_val;
  logic [HW-1:0] rd_idx;
  logic          bad_digit;

  // Operand currently receiving digits; RESULT entries edit save1.
  assign active_val = (state == ENTER_B) ? save2 : save1;
  // Newest entry sits just behind the write pointer; wraps naturally in HW bits.
  assign rd_idx     = wptr - HW'(1) - recall_idx;
  assign bad_digit  = DECIMAL && (num > 4'd9);
  assign active_b   = (state == ENTER_B);

  // NOTE: every signal driven here gets its hold value first, so no branch
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state;
    save1_d = save1;
    save2_d = save2;
    op_d    = op_out;
    cnt_d   = digit_cnt;
    err_d   = 1'b0;
    push    = 1'b0;

    if (clear_enable) begin
      save1_d = '0;
      save2_d = '0;
      op_d    = 4'b0000;
      cnt_d   = '0;
      state_d = ENTER_A;
    end else if (equ_enable) begin
      if (state == ENTER_B || (state == RESULT && op_out != 4'b0000)) begin
        // Repeat equals in RESULT reuses the kept operator with save2 == 0.
        save1_d = res;
        save2_d = '0;
        cnt_d   = '0;
        push    = 1'b1;
        state_d = RESULT;
      end else begin
        err_d = 1'b1;
      end
    end else if (op_enable) begin
      op_d = 4'b0001 << operator;
      if (state != ENTER_B) begin
        save2_d = '0;
        cnt_d   = '0;
        state_d = ENTER_B;
      end
    end else if (recall_enable) begin
      if ({1'b0, recall_idx} >= hist_count) begin
        err_d = 1'b1;
      end else begin
        cnt_d = DIGITS_C;
        if (state == ENTER_B) begin
          save2_d = hist[rd_idx];
        end else begin
          save1_d = hist[rd_idx];
          state_d = ENTER_A;
        end
      end
    end else if (back_enable) begin
      if (state == RESULT || digit_cnt == '0) begin
        err_d = 1'b1;
      end else begin
        cnt_d = digit_cnt - CW'(1);
        if (state == ENTER_B) save2_d = active_val >> 4;
        else                  save1_d = active_val >> 4;
      end
    end else if (digit_enable) begin
      if (bad_digit) begin
        err_d = 1'b1;
      end else if (state == RESULT) begin
        // A fresh digit after a result starts a new calculation.
        save1_d = W'(num);
        cnt_d   = CW'(1);
        op_d    = 4'b0000;
        state_d = ENTER_A;
      end else if (digit_cnt == DIGITS_C) begin
        err_d = 1'b1;
      end else begin
        cnt_d = digit_cnt + CW'(1);
        if (state == ENTER_B) save2_d = (active_val << 4) | W'(num);
        else                  save1_d = (active_val << 4) | W'(num);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ENTER_A;
      save1      <= '0;
      save2      <= '0;
      op_out     <= 4'b0000;
      digit_cnt  <= '0;
      entry_full <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      save1      <= save1_d;
      save2      <= save2_d;
      op_out     <= op_d;
      digit_cnt  <= cnt_d;
      entry_full <= (cnt_d == DIGITS_C);
      err        <= err_d;
    end
  end

  // NOTE: the history array is reset along with everything else because a
  // reset must leave no trace of earlier results; it is only HIST_DEPTH words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
      wptr       <= '0;
      hist_count <= '0;
    end else if (push) begin
      hist[wptr] <= res;
      wptr       <= wptr + HW'(1);
      if (hist_count != HIST_FULL) hist_count <= hist_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_calc_operand_mem.sv
// Self-checking bench for calc_operand_mem. A reference model kept as plain
// integers plus a newest-first queue of results predicts every output after
// each command; directed steps follow the calculator scenarios, then a
// randomized command stream exercises the priority and error rules.

module tb_calc_operand_mem;

  localparam int DIGITS = 4;
  localparam int HD     = 4;
  localparam int W      = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    num = '0;
  logic          digit_enable = 1'b0;
  logic          back_enable = 1'b0;
  logic [1:0]    operator = '0;
  logic          op_enable = 1'b0;
  logic          equ_enable = 1'b0;
  logic [W-1:0]  res = '0;
  logic          recall_enable = 1'b0;
  logic [1:0]    recall_idx = '0;
  logic          clear_enable = 1'b0;
  logic [W-1:0]  save1, save2;
  logic [3:0]    op_out;
  logic          active_b;
  logic [2:0]    digit_cnt;
  logic          entry_full;
  logic [2:0]    hist_count;
  logic          err;

  calc_operand_mem #(.DIGITS(DIGITS), .HIST_DEPTH(HD), .DECIMAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .num(num), .digit_enable(digit_enable),
    .back_enable(back_enable), .operator(operator), .op_enable(op_enable),
    .equ_enable(equ_enable), .res(res), .recall_enable(recall_enable),
    .recall_idx(recall_idx), .clear_enable(clear_enable), .save1(save1),
    .save2(save2), .op_out(op_out), .active_b(active_b), .digit_cnt(digit_cnt),
    .entry_full(entry_full), .hist_count(hist_count), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = entering A, 1 = entering B, 2 = showing result.
  int          m_mode;
  int          m_a, m_b, m_cnt, m_op;   // m_op = -1 when no operator latched
  bit          m_err;
  int          m_hist[$];               // newest result at index 0

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_a = 0; m_b = 0; m_cnt = 0; m_op = -1; m_err = 0;
    m_hist.delete();
  endtask

  task automatic model_step(input bit clr, input bit equ, input bit opn, input bit rec,
                            input bit bck, input bit dig, input int n, input int oper,
                            input int idx, input int r);
    m_err = 0;
    if (clr) begin
      m_a = 0; m_b = 0; m_op = -1; m_cnt = 0; m_mode = 0;
    end else if (equ) begin
      if (m_mode == 1 || (m_mode == 2 && m_op >= 0)) begin
        m_a = r; m_b = 0; m_cnt = 0; m_mode = 2;
        m_hist.push_front(r);
        if (m_hist.size() > HD) void'(m_hist.pop_back());
      end else m_err = 1;
    end else if (opn) begin
      m_op = oper;
      if (m_mode != 1) begin m_b = 0; m_cnt = 0; m_mode = 1; end
    end else if (rec) begin
      if (idx >= m_hist.size()) m_err = 1;
      else begin
        m_cnt = DIGITS;
        if (m_mode == 1) m_b = m_hist[idx];
        else begin m_a = m_hist[idx]; m_mode = 0; end
      end
    end else if (bck) begin
      if (m_mode == 2 || m_cnt == 0) m_err = 1;
      else begin
        if (m_mode == 1) m_b = m_b / 16; else m_a = m_a / 16;
        m_cnt--;
      end
    end else if (dig) begin
      if (n > 9) m_err = 1;
      else if (m_mode == 2) begin m_a = n; m_cnt = 1; m_op = -1; m_mode = 0; end
      else if (m_cnt == DIGITS) m_err = 1;
      else begin
        if (m_mode == 1) m_b = (m_b * 16 + n) % 65536;
        else             m_a = (m_a * 16 + n) % 65536;
        m_cnt++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".save1"},      32'(save1),      32'(m_a));
    check({tag, ".save2"},      32'(save2),      32'(m_b));
    check({tag, ".op_out"},     32'(op_out),     (m_op < 0) ? 32'd0 : (32'd1 << m_op));
    check({tag, ".active_b"},   32'(active_b),   32'(m_mode == 1));
    check({tag, ".digit_cnt"},  32'(digit_cnt),  32'(m_cnt));
    check({tag, ".entry_full"}, 32'(entry_full), 32'(m_cnt == DIGITS));
    check({tag, ".hist_count"}, 32'(hist_count), 32'(m_hist.size()));
    check({tag, ".err"},        32'(err),        32'(m_err));
  endtask

  // Drive one command before the edge, step the model, check #1 after the edge.
  task automatic cmd(input string tag, input bit clr, input bit equ, input bit opn,
                     input bit rec, input bit bck, input bit dig, input int n,
                     input int oper, input int idx, input int r);
    clear_enable = clr; equ_enable = equ; op_enable = opn; recall_enable = rec;
    back_enable = bck; digit_enable = dig; num = 4'(n); operator = 2'(oper);
    recall_idx = 2'(idx); res = 16'(r);
    model_step(clr, equ, opn, rec, bck, dig, n, oper, idx, r);
    @(posedge clk);
    #1;
    check_all(tag);
    {clear_enable, equ_enable, op_enable, recall_enable, back_enable, digit_enable} = '0;
  endtask

  task automatic digit(input string tag, input int n);
    cmd(tag, 0, 0, 0, 0, 0, 1, n, 0, 0, 0);
  endtask

  task automatic equals(input string tag, input int r);
    cmd(tag, 0, 1, 0, 0, 0, 0, 0, 0, 0, r);
  endtask

  task automatic recall(input string tag, input int idx);
    cmd(tag, 0, 0, 0, 1, 0, 0, 0, 0, idx, 0);
  endtask

  task automatic clear(input string tag);
    cmd(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    // Reset state
    #12;
    check_all("reset");
    @(negedge clk) rst_n = 1'b1;

    // Five digits into a four-digit operand
    for (int i = 1; i <= 5; i++) digit($sformatf("dig%0d", i), i);
    check("tp1_save1", 32'(save1), 32'h1234);
    check("tp1_full", 32'(entry_full), 32'd1);
    check("tp1_err", 32'(err), 32'd1);

    // Operand B entry with backspace
    clear("clr1");
    digit("d9", 9);
    digit("d8", 8);
    cmd("op2", 0, 0, 1, 0, 0, 0, 0, 2, 0, 0);
    digit("d7", 7);
    cmd("back", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    digit("d5", 5);
    check("tp2_op", 32'(op_out), 32'h4);
    check("tp2_save2", 32'(save2), 32'h5);
    check("tp2_act", 32'(active_b), 32'd1);

    // Equals, repeat equals, recall beyond a partly filled history
    equals("eq1", 16'h0103);
    check("tp3_save1", 32'(save1), 32'h0103);
    equals("eq2", 16'h0108);
    check("tp3_hist", 32'(hist_count), 32'd2);
    recall("rec_oob", 2);
    check("tp4_oob_err", 32'(err), 32'd1);
    cmd("back_res", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Fill past the history depth, then recall newest and oldest
    equals("eq3", 16'h0011);
    equals("eq4", 16'h0022);
    equals("eq5", 16'h0033);
    check("tp4_hist", 32'(hist_count), 32'd4);
    recall("rec0", 0);
    check("tp4_rec0", 32'(save1), 32'h0033);
    recall("rec3", 3);
    check("tp4_rec3", 32'(save1), 32'h0108);

    // Decimal rejection, then clear beating equ and digit in the same cycle
    clear("clr2");
    digit("dA", 4'hA);
    check("tp5_dec_err", 32'(err), 32'd1);
    cmd("clr_mix", 1, 1, 0, 0, 0, 1, 3, 0, 0, 16'hBEEF);
    check("tp5_hist_kept", 32'(hist_count), 32'd4);
    equals("eq_in_a", 16'h1111);

    // Asynchronous reset in the middle of operand B entry
    digit("r1", 1);
    cmd("rop", 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    digit("r2", 2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk) rst_n = 1'b1;

    // Randomized command stream against the model
    for (int i = 0; i < 600; i++) begin
      cmd($sformatf("rnd%0d", i),
          $urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 7) == 0,  $urandom_range(0, 5) == 0,
          $urandom_range(0, 5) == 0,  $urandom_range(0, 1) == 0,
          int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)),  int'($urandom_range(0, 65535)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
